// File: rtl/unified_mem_arbiter_pkg.sv
// Shared definitions for the IF/MEM unified memory arbiter.
package unified_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GNT_IF = 2'd1,
    ST_GNT_DM = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_e;

  localparam logic [31:0] ABORT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/unified_mem_arbiter_watchdog.sv
// Grant-phase watchdog: loaded on clear, counts down while enabled,
// expires on the TIMEOUT-th enabled cycle after a clear.
module arb_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TC_LOAD = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = TC_LOAD;
    end else if (enable && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  assign expire = enable && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Serialises IF fetches and MEM loads/stores onto one req/ack memory port,
// with a per-access watchdog and a fetch-starvation bound.
//
//   state   | meaning
//   IDLE    | no access in flight; arbitrate between if_req and dm_req
//   GNT_IF  | fetch on the memory port, waiting for mem_ack
//   GNT_DM  | load/store on the memory port, waiting for mem_ack
//   RESP    | one-cycle ready pulse to the owner; requests ignored
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int TIMEOUT    = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ready,
  output logic          stall,
  output logic          err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
);

  localparam int SW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  arb_state_e    state_q, state_d;
  logic          gnt_if_q, gnt_if_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;
  logic          err_q, err_d;

  logic grant_if;
  logic complete;
  logic wd_clear, wd_en, wd_expire;

  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (wd_clear),
    .enable (wd_en),
    .expire (wd_expire)
  );

  always_comb begin
    state_d     = state_q;
    gnt_if_d    = gnt_if_q;
    starve_d    = starve_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    err_d       = err_q;
    grant_if    = 1'b0;
    complete    = 1'b0;
    wd_clear    = 1'b0;
    wd_en       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (if_req || dm_req) begin
          // DM is the older instruction unless fetch has been starved too long
          grant_if  = if_req && (!dm_req || (starve_q == STARVE_LIM));
          gnt_if_d  = grant_if;
          wd_clear  = 1'b1;
          mem_req_d = 1'b1;
          if (grant_if) begin
            state_d     = ST_GNT_IF;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            starve_d    = '0;
          end else begin
            state_d     = ST_GNT_DM;
            mem_we_d    = dm_we;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
            if (!if_req) begin
              starve_d = '0;
            end else if (starve_q != STARVE_LIM) begin
              starve_d = starve_q + 1'b1;
            end
          end
        end
      end

      ST_GNT_IF, ST_GNT_DM: begin
        wd_en = 1'b1;
        if (mem_ack) begin
          complete = 1'b1;
          if (gnt_if_q) begin
            if_rdata_d = mem_rdata;
          end else begin
            dm_rdata_d = mem_we_q ? '0 : mem_rdata;
          end
        end else if (wd_expire) begin
          complete = 1'b1;
          err_d    = 1'b1;
          if (gnt_if_q) begin
            if_rdata_d = DW'(ABORT_DATA);
          end else begin
            dm_rdata_d = DW'(ABORT_DATA);
          end
        end
        if (complete) begin
          state_d     = ST_RESP;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      gnt_if_q    <= 1'b0;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_if_q    <= gnt_if_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      err_q       <= err_d;
    end
  end

  assign if_ready  = (state_q == ST_RESP) && gnt_if_q;
  assign dm_ready  = (state_q == ST_RESP) && !gnt_if_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign err       = err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign stall     = (if_req && !if_ready) || (dm_req && !dm_ready);

endmodule
